// File: rtl/serial_byte_rx.sv
// 8N1 serial receiver, LSB first. Recovers bytes from the asynchronous Rx line and
// presents each good byte on Dato with a one-cycle LoadDato strobe.
module serial_byte_rx #(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Rx,
  output logic [7:0] Dato,
  output logic       LoadDato,
  output logic       ErrorTrama,
  output logic       Ocupado
);

  localparam logic [15:0] BitLast  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HalfLast = 16'((CLKS_PER_BIT / 2) - 1);

  typedef enum logic [2:0] {
    Idle,
    Start,
    Data,
    Stop,
    WaitHi
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  sh_q, sh_d;
  logic [7:0]  dato_q, dato_d;
  logic        load_q, load_d;
  logic        err_q, err_d;
  logic        sync1_q, rxSync_q;

  // Both synchroniser stages reset to the idle-line level so reset never fakes a start bit.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      sync1_q  <= 1'b1;
      rxSync_q <= 1'b1;
    end else begin
      sync1_q  <= Rx;
      rxSync_q <= sync1_q;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= Idle;
      cnt_q   <= 16'd0;
      idx_q   <= 3'd0;
      sh_q    <= 8'd0;
      dato_q  <= 8'd0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      dato_q  <= dato_d;
      load_q  <= load_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    dato_d  = dato_q;
    load_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      Idle: begin
        cnt_d = 16'd0;
        idx_d = 3'd0;
        if (!rxSync_q) begin
          state_d = Start;
        end
      end

      // A start bit that is gone by mid-bit is treated as a glitch.
      Start: begin
        if (cnt_q == HalfLast) begin
          cnt_d   = 16'd0;
          state_d = rxSync_q ? Idle : Data;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      Data: begin
        if (cnt_q == BitLast) begin
          cnt_d = 16'd0;
          sh_d  = {rxSync_q, sh_q[7:1]};
          if (idx_q == 3'd7) begin
            idx_d   = 3'd0;
            state_d = Stop;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      Stop: begin
        if (cnt_q == BitLast) begin
          cnt_d = 16'd0;
          if (rxSync_q) begin
            dato_d  = sh_q;
            load_d  = 1'b1;
            state_d = Idle;
          end else begin
            err_d   = 1'b1;
            state_d = WaitHi;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      // Hold off until a break releases so its low level is not taken as a start bit.
      WaitHi: begin
        cnt_d = 16'd0;
        if (rxSync_q) begin
          state_d = Idle;
        end
      end

      default: begin
        state_d = Idle;
      end
    endcase
  end

  assign Dato       = dato_q;
  assign LoadDato   = load_q;
  assign ErrorTrama = err_q;
  assign Ocupado    = (state_q != Idle);

endmodule

// File: tb/tb_serial_byte_rx.sv
// Directed bench for serial_byte_rx at 16 clocks per bit; expected bytes are queued
// when a frame is sent and popped when the receiver strobes LoadDato.
module tb_serial_byte_rx;

  localparam int Cpb = 16;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Rx = 1'b1;
  logic [7:0] Dato;
  logic       LoadDato;
  logic       ErrorTrama;
  logic       Ocupado;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int loadCount = 0;
  int errCount = 0;
  int lastLoadCycle = 0;
  int prevLoadCycle = 0;
  int startCycle = 0;
  int errPending = 0;
  int baseLoad = 0;
  int baseErr = 0;
  logic [7:0] expQ[$];
  logic [7:0] lastGood = 8'h00;
  logic [7:0] anterior = 8'h00;
  logic [7:0] actual = 8'h00;

  serial_byte_rx #(.CLKS_PER_BIT(Cpb)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Rx        (Rx),
    .Dato      (Dato),
    .LoadDato  (LoadDato),
    .ErrorTrama(ErrorTrama),
    .Ocupado   (Ocupado)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) cycle <= cycle + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] b, input logic stopBit);
    Rx = 1'b0;
    startCycle = cycle;
    tick(Cpb);
    for (int i = 0; i < 8; i++) begin
      Rx = b[i];
      tick(Cpb);
    end
    Rx = stopBit;
    tick(Cpb);
  endtask

  // Scoreboard side: every strobe must match something the stimulus announced.
  always @(negedge Clock) begin
    if (Reset) begin
      lastGood = 8'h00;
    end
    if (LoadDato) begin
      loadCount++;
      prevLoadCycle = lastLoadCycle;
      lastLoadCycle = cycle;
      anterior = actual;
      actual = Dato;
      checkOutput("LoadExpected", 32'(expQ.size() != 0), 32'd1);
      if (expQ.size() != 0) begin
        lastGood = expQ.pop_front();
        checkOutput("LoadByte", 32'(Dato), 32'(lastGood));
      end
      checkOutput("StrobeExclusive", 32'(ErrorTrama), 32'd0);
    end
    if (ErrorTrama) begin
      errCount++;
      checkOutput("ErrExpected", 32'(errPending != 0), 32'd1);
      if (errPending > 0) errPending--;
      checkOutput("DatoHeldOnError", 32'(Dato), 32'(lastGood));
    end
  end

  initial begin
    Reset = 1'b1;
    Rx = 1'b1;
    tick(3);
    checkOutput("ResetDato", 32'(Dato), 32'h00);
    checkOutput("ResetLoad", 32'(LoadDato), 32'd0);
    checkOutput("ResetErr", 32'(ErrorTrama), 32'd0);
    checkOutput("ResetBusy", 32'(Ocupado), 32'd0);
    Reset = 1'b0;
    tick(5);

    // Single frame with latency from start-bit pin edge to visible strobe
    baseLoad = loadCount;
    baseErr = errCount;
    expQ.push_back(8'hA5);
    applyStimulus(8'hA5, 1'b1);
    tick(10);
    checkOutput("SingleLoadCount", 32'(loadCount - baseLoad), 32'd1);
    checkOutput("SingleLatency", 32'(lastLoadCycle - startCycle), 32'd155);
    checkOutput("SingleNoErr", 32'(errCount - baseErr), 32'd0);
    checkOutput("SingleDato", 32'(Dato), 32'hA5);
    checkOutput("SingleIdle", 32'(Ocupado), 32'd0);

    // Back-to-back frames with no idle between them
    baseLoad = loadCount;
    expQ.push_back(8'h00);
    expQ.push_back(8'hFF);
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'hFF, 1'b1);
    tick(10);
    checkOutput("B2BLoadCount", 32'(loadCount - baseLoad), 32'd2);
    checkOutput("B2BSpacing", 32'(lastLoadCycle - prevLoadCycle), 32'd160);
    checkOutput("B2BDato", 32'(Dato), 32'hFF);

    // Short glitch aborts in the start state
    baseLoad = loadCount;
    baseErr = errCount;
    Rx = 1'b0;
    tick(4);
    checkOutput("GlitchBusy", 32'(Ocupado), 32'd1);
    Rx = 1'b1;
    tick(20);
    checkOutput("GlitchIdle", 32'(Ocupado), 32'd0);
    checkOutput("GlitchNoLoad", 32'(loadCount - baseLoad), 32'd0);
    checkOutput("GlitchNoErr", 32'(errCount - baseErr), 32'd0);

    // Framing error followed by a held-low break, then a good frame
    baseLoad = loadCount;
    baseErr = errCount;
    errPending++;
    applyStimulus(8'h3C, 1'b0);
    tick(40);
    checkOutput("FrameErrCount", 32'(errCount - baseErr), 32'd1);
    checkOutput("FrameErrDatoHeld", 32'(Dato), 32'hFF);
    checkOutput("FrameErrBusy", 32'(Ocupado), 32'd1);
    checkOutput("FrameErrNoLoad", 32'(loadCount - baseLoad), 32'd0);
    Rx = 1'b1;
    tick(20);
    checkOutput("BreakReleased", 32'(Ocupado), 32'd0);
    expQ.push_back(8'h81);
    applyStimulus(8'h81, 1'b1);
    tick(10);
    checkOutput("AfterErrLoad", 32'(loadCount - baseLoad), 32'd1);
    checkOutput("AfterErrDato", 32'(Dato), 32'h81);

    // Reset during data bit 4 of 0x55 discards the partial frame
    baseLoad = loadCount;
    Rx = 1'b0;
    tick(Cpb);
    for (int i = 0; i < 4; i++) begin
      Rx = ((8'h55 >> i) & 8'h01) != 8'h00;
      tick(Cpb);
    end
    Rx = 1'b1;
    tick(8);
    Reset = 1'b1;
    tick(1);
    Reset = 1'b0;
    checkOutput("MidResetDato", 32'(Dato), 32'h00);
    checkOutput("MidResetBusy", 32'(Ocupado), 32'd0);
    tick(200);
    checkOutput("MidResetNoLoad", 32'(loadCount - baseLoad), 32'd0);
    expQ.push_back(8'h12);
    applyStimulus(8'h12, 1'b1);
    tick(10);
    checkOutput("PostResetLoad", 32'(loadCount - baseLoad), 32'd1);
    checkOutput("PostResetDato", 32'(Dato), 32'h12);

    // Byte-history stage fed by Dato/LoadDato
    expQ.push_back(8'h11);
    expQ.push_back(8'h22);
    applyStimulus(8'h11, 1'b1);
    applyStimulus(8'h22, 1'b1);
    tick(10);
    checkOutput("HistAnterior", 32'(anterior), 32'h11);
    checkOutput("HistActual", 32'(actual), 32'h22);

    checkOutput("QueueDrained", 32'(expQ.size()), 32'd0);
    checkOutput("ErrDrained", 32'(errPending), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
